// File: rtl/iq_pkg.sv
// iq_pkg: shared widths, amplitude coefficients and saturation helpers for the iq_* blocks.
package iq_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_GUARD = 2;
  localparam int AMP_SH1 = 2;
  localparam int AMP_SH2 = 3;
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
  function automatic logic [31:0] sat_u(input logic [31:0] x, input int w);
    logic [31:0] hi;
    hi = (32'd1 << w) - 32'd1;
    return x > hi ? hi : x;
  endfunction
endpackage

// File: rtl/amp_est.sv
// amp_est: max + 3/8 min magnitude estimate over two pipeline stages, with I/Q carried alongside.
module amp_est import iq_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic                         clr,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] q_in,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] q_out,
  output logic        [DATA_WIDTH-1:0] amp,
  output logic                         valid_out,
  output logic                         clip
);
  logic [DATA_WIDTH-1:0] ai, aq, mx, mn;
  logic signed [DATA_WIDTH-1:0] i2, q2;
  logic v2;
  logic [DATA_WIDTH:0] sum;
  // |-2^(W-1)| wraps to 2^(W-1), which is exact when read as unsigned
  always_comb begin
    ai = i_in[DATA_WIDTH-1] ? ~i_in + 1'b1 : i_in;
    aq = q_in[DATA_WIDTH-1] ? ~q_in + 1'b1 : q_in;
    sum = {1'b0, mx} + {1'b0, mn >> AMP_SH1} + {1'b0, mn >> AMP_SH2};
    clip = ce & ~clr & v2 & (sat_u(32'(sum), DATA_WIDTH) != 32'(sum));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= '0;
      mn <= '0;
      i2 <= '0;
      q2 <= '0;
      v2 <= 1'b0;
      i_out <= '0;
      q_out <= '0;
      amp <= '0;
      valid_out <= 1'b0;
    end else if (ce) begin
      v2 <= valid_in & ~clr;
      valid_out <= v2 & ~clr;
      if (valid_in && !clr) begin
        mx <= ai >= aq ? ai : aq;
        mn <= ai >= aq ? aq : ai;
        i2 <= i_in;
        q2 <= q_in;
      end
      if (v2 && !clr) begin
        i_out <= i2;
        q_out <= q2;
        amp <= DATA_WIDTH'(sat_u(32'(sum), DATA_WIDTH));
      end
    end
  end
endmodule

// File: rtl/iq_4sum.sv
// iq_4sum: 4-sample sliding I/Q sums with amplitude estimate, timed to feed iq_analyse.
module iq_4sum import iq_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SUM_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic                         strobe_in,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] I_in,
  input  logic signed [DATA_WIDTH-1:0] Q_in,
  output logic signed [DATA_WIDTH-1:0] I_4sum,
  output logic signed [DATA_WIDTH-1:0] Q_4sum,
  output logic        [DATA_WIDTH-1:0] Amp_4sum,
  output logic                         strobe_out,
  output logic                         ovf
);
  localparam int AW = DATA_WIDTH + ACC_GUARD;
  logic signed [DATA_WIDTH-1:0] hist_i [4];
  logic signed [DATA_WIDTH-1:0] hist_q [4];
  logic signed [AW-1:0] acc_i, acc_q, sh_i, sh_q;
  logic signed [DATA_WIDTH-1:0] i1, q1;
  logic [2:0] fill;
  logic take, v0, v1, clip_s, amp_clip, so_r;
  always_comb begin
    take = ce & strobe_in & ~clr;
    sh_i = acc_i >>> SUM_SHIFT;
    sh_q = acc_q >>> SUM_SHIFT;
    clip_s = v0 & ((sat_s(32'(sh_i), DATA_WIDTH) != 32'(sh_i)) | (sat_s(32'(sh_q), DATA_WIDTH) != 32'(sh_q)));
  end
  // stage 0: history shift and running sum, valid only once the window is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        hist_i[k] <= '0;
        hist_q[k] <= '0;
      end
      acc_i <= '0;
      acc_q <= '0;
      fill <= '0;
      v0 <= 1'b0;
    end else if (ce) begin
      if (clr) begin
        for (int k = 0; k < 4; k++) begin
          hist_i[k] <= '0;
          hist_q[k] <= '0;
        end
        acc_i <= '0;
        acc_q <= '0;
        fill <= '0;
        v0 <= 1'b0;
      end else begin
        v0 <= take & (fill >= 3'd3);
        if (take) begin
          hist_i <= '{I_in, hist_i[0], hist_i[1], hist_i[2]};
          hist_q <= '{Q_in, hist_q[0], hist_q[1], hist_q[2]};
          acc_i <= acc_i + AW'(I_in) - AW'(hist_i[3]);
          acc_q <= acc_q + AW'(Q_in) - AW'(hist_q[3]);
          fill <= fill == 3'd4 ? fill : fill + 3'd1;
        end
      end
    end
  end
  // stage 1: scale and clip to the output range; ovf is sticky until clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1 <= '0;
      q1 <= '0;
      v1 <= 1'b0;
      ovf <= 1'b0;
    end else if (ce) begin
      v1 <= v0 & ~clr;
      ovf <= clr ? 1'b0 : ovf | clip_s | amp_clip;
      if (v0 && !clr) begin
        i1 <= DATA_WIDTH'(sat_s(32'(sh_i), DATA_WIDTH));
        q1 <= DATA_WIDTH'(sat_s(32'(sh_q), DATA_WIDTH));
      end
    end
  end
  amp_est #(.DATA_WIDTH(DATA_WIDTH)) u_amp (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .clr(clr),
    .valid_in(v1),
    .i_in(i1),
    .q_in(q1),
    .i_out(I_4sum),
    .q_out(Q_4sum),
    .amp(Amp_4sum),
    .valid_out(so_r),
    .clip(amp_clip)
  );
  // a pending pulse stays registered through a ce pause and is shown once ce returns
  assign strobe_out = so_r & ce;
endmodule

// File: tb/tb_iq_4sum.sv
// tb_iq_4sum: directed checks of iq_4sum with mean (SUM_SHIFT=2) and raw (SUM_SHIFT=0) instances.
module tb_iq_4sum;
  logic clk = 1'b0;
  logic rst_n, ce, strobe_in, clr;
  logic signed [15:0] I_in, Q_in;
  logic signed [15:0] i_m, q_m, i_r, q_r;
  logic [15:0] a_m, a_r;
  logic so_m, so_r, ovf_m, ovf_r;
  int total = 0;
  int passes = 0;
  int cnt;
  logic ce_prev;
  always #5 clk = ~clk;
  iq_4sum #(.DATA_WIDTH(16), .SUM_SHIFT(2)) u_mean (
    .clk(clk), .rst_n(rst_n), .ce(ce), .strobe_in(strobe_in), .clr(clr),
    .I_in(I_in), .Q_in(Q_in), .I_4sum(i_m), .Q_4sum(q_m), .Amp_4sum(a_m),
    .strobe_out(so_m), .ovf(ovf_m)
  );
  iq_4sum #(.DATA_WIDTH(16), .SUM_SHIFT(0)) u_raw (
    .clk(clk), .rst_n(rst_n), .ce(ce), .strobe_in(strobe_in), .clr(clr),
    .I_in(I_in), .Q_in(Q_in), .I_4sum(i_r), .Q_4sum(q_r), .Amp_4sum(a_r),
    .strobe_out(so_r), .ovf(ovf_r)
  );
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask
  task automatic send(input logic signed [15:0] i, input logic signed [15:0] q);
    @(negedge clk);
    strobe_in = 1'b1;
    I_in = i;
    Q_in = q;
    @(negedge clk);
    strobe_in = 1'b0;
  endtask
  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  task automatic chk_mean(input string tag, input int i, input int q, input int a);
    chk({tag, "_so"}, so_m, 1);
    chk({tag, "_i"}, i_m, i);
    chk({tag, "_q"}, q_m, q);
    chk({tag, "_amp"}, a_m, a);
  endtask
  initial begin
    rst_n = 1'b0;
    ce = 1'b1;
    strobe_in = 1'b0;
    clr = 1'b0;
    I_in = '0;
    Q_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_so", so_m, 0);
    chk("rst_i", i_m, 0);
    chk("rst_amp", a_m, 0);
    chk("rst_ovf", ovf_m, 0);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      send(-16'sd8, 16'sd7);
      repeat (3) @(negedge clk);
      if (n < 3) chk("fill_noso", so_m, 0);
      else chk_mean("fill", -8, 7, 9);
      repeat (16) @(negedge clk);
    end
    repeat (4) send(16'sd30, 16'sd40);
    repeat (3) @(negedge clk);
    chk_mean("tone", 30, 40, 50);
    send(-16'sd30, -16'sd40);
    repeat (3) @(negedge clk);
    chk_mean("tone_neg", 15, 20, 24);
    repeat (4) send(16'sd25, 16'sd20);
    repeat (3) @(negedge clk);
    chk_mean("quad", 25, 20, 32);
    send(16'sd0, 16'sd0);
    repeat (3) send(-16'sd1, 16'sd0);
    repeat (3) @(negedge clk);
    chk_mean("floor", -1, 0, 1);
    pulse_clr();
    repeat (4) send(16'sd32767, -16'sd32768);
    repeat (3) @(negedge clk);
    chk("sat_raw_so", so_r, 1);
    chk("sat_raw_i", i_r, 32767);
    chk("sat_raw_q", q_r, -32768);
    chk("sat_raw_amp", a_r, 45054);
    chk("sat_raw_ovf", ovf_r, 1);
    chk_mean("sat_mean", 32767, -32768, 45054);
    chk("sat_mean_ovf", ovf_m, 0);
    repeat (10) @(negedge clk);
    chk("ovf_sticky", ovf_r, 1);
    pulse_clr();
    chk("ovf_clr", ovf_r, 0);
    chk("clr_keep_i", i_r, 32767);
    cnt = 0;
    ce_prev = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (so_m) cnt++;
      if (!ce_prev) begin
        chk("ce_off_so", so_m, 0);
        chk("ce_off_i", i_m, 12);
      end
      ce = !(k >= 8 && k < 13);
      ce_prev = ce;
      strobe_in = k < 13;
      I_in = 16'sd12;
      Q_in = -16'sd4;
    end
    ce = 1'b1;
    strobe_in = 1'b0;
    chk("burst_count", cnt, 5);
    chk("burst_i", i_m, 12);
    chk("burst_q", q_m, -4);
    chk("burst_amp", a_m, 13);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_i", i_m, 0);
    chk("arst_amp", a_m, 0);
    chk("arst_so", so_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      send(16'sd8, 16'sd8);
      repeat (3) @(negedge clk);
      if (n < 3) chk("refill_noso", so_m, 0);
      else chk_mean("refill", 8, 8, 11);
    end
    @(negedge clk);
    strobe_in = 1'b1;
    clr = 1'b1;
    I_in = 16'sd1000;
    Q_in = 16'sd0;
    @(negedge clk);
    strobe_in = 1'b0;
    clr = 1'b0;
    chk("clrs_keep_i", i_m, 8);
    for (int n = 0; n < 4; n++) begin
      send(16'sd4, 16'sd0);
      repeat (3) @(negedge clk);
      if (n < 3) chk("clrs_noso", so_m, 0);
      else chk_mean("clrs", 4, 0, 4);
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
